set_assoc_write_through_cache: RTL and testbench
================================================

Name: set_assoc_write_through_cache

Overview:
- Parametrised 2-way set-associative, write-through, no-write-allocate cache sitting between the CPU port and the RAM controller.
- Successor to the direct-mapped cache. Adds:
  - per-line valid bits;
  - per-set LRU replacement;
  - an explicit request/busy handshake;
  - fetched data forwarded straight to douta;
  - a completion pulse.
- Tag width is derived from the parameters.

Parameters:
- ADDRESS_SPACE, 12, width of the full memory word address.
- DATA_SIZE, 32, word width in bits.
- SET_BITS, 9, log2 of the set count. Total capacity = 2*2^SET_BITS words.
- TAG_BITS, ADDRESS_SPACE-SET_BITS, derived; do not override.

Ports:
- clka  input  1  clock; all logic on rising edge.
- rsta  input  1  reset, synchronous, active-high.
- req  input  1  CPU request strobe; sampled only when busy=0.
- wea  input  1  1=write, 0=read; qualified by req.
- addra  input  ADDRESS_SPACE  word address; index = addra[SET_BITS-1:0], tag = upper TAG_BITS.
- dina  input  DATA_SIZE  write data.
- douta  output  DATA_SIZE  read data; valid when done=1 and request was a read.
- done  output  1  one-cycle completion pulse.
- hit  output  1  valid with done: 1 = completed from cache without RAM access.
- busy  output  1  high while a request is in flight; new req ignored.
- fetch  output  1  read request to RAM controller; level, held until fetch_ack.
- flush  output  1  write request to RAM controller; level, held until flush_ack.
- mem_addr  output  ADDRESS_SPACE  RAM address, stable while fetch or flush is high.
- mem_dout  output  DATA_SIZE  write data to RAM, stable while flush is high.
- mem_din  input  DATA_SIZE  RAM read data, valid with fetch_ack.
- fetch_ack  input  1  RAM data valid; single-cycle.
- flush_ack  input  1  RAM write accepted; single-cycle.

Behaviour:
- Storage per set: 2 ways × {valid, tag, data}, plus one LRU bit (names the way to evict next).
- Reset (rsta=1 at clock edge):
  - clears all valid bits and LRU bits to 0;
  - state=IDLE;
  - douta=0, done=0, hit=0, busy=0, fetch=0, flush=0, mem_addr=0, mem_dout=0.
  - Reset wins over any simultaneous req or ack.
  - Reset mid-FETCH/FLUSH aborts the transaction: no cache update, no done pulse.
- States: IDLE, FETCH, FLUSH. done and hit default to 0 every cycle unless set below.
- IDLE with req=1, wea=0 (read). Lookup is combinational on the registered arrays.
  - Hit in way w:
    - next edge: douta <= data[w], done=1, hit=1, LRU <= ~w;
    - stay IDLE. Latency 1 cycle.
  - Miss:
    - next edge: fetch=1, busy=1, mem_addr <= addra;
    - latch index and tag; go to FETCH.
- IDLE with req=1, wea=1 (write):
  - On a hit in way w: data[w] <= dina, LRU <= ~w.
  - On a miss: cache unchanged (no allocate).
  - Always: flush=1, busy=1, mem_addr <= addra, mem_dout <= dina; go to FLUSH.
- FETCH, on fetch_ack=1:
  - Victim way: first invalid way (way0 preferred); if both ways are valid, the LRU way.
  - Write {valid=1, latched tag, mem_din} into the victim; LRU <= ~victim.
  - douta <= mem_din (forwarded, not re-read from the array).
  - done=1, hit=0, fetch=0, busy=0; go to IDLE.
- FLUSH, on flush_ack=1:
  - flush=0, busy=0, done=1, hit=0; go to IDLE.
  - douta is unchanged.
- Ignored inputs:
  - fetch_ack outside FETCH and flush_ack outside FLUSH are ignored.
  - req while busy=1 is ignored; the CPU must re-issue.
- Back-to-back reads:
  - A read hit may be followed by req in the very next cycle.
  - After miss completion, req is accepted in the same cycle as done (busy=0).
- Stale lines: a line with valid=0 never hits, whatever its tag/data contents.
- No X-propagation: every output has a defined value from the first edge after reset.

Test Plan:
- Reset, then read 0x005 → done in 1 cycle with hit=0? No: miss, so fetch=1 with mem_addr=0x005. Drive fetch_ack with mem_din=0xDEADBEEF → next edge douta=0xDEADBEEF, done=1, hit=0. Re-read 0x005 → 1 cycle later done=1, hit=1, douta=0xDEADBEEF.
- Fill conflicting addresses 0x005, 0x205 (same set, SET_BITS=9), then read 0x005 (0x005 becomes MRU) and read 0x405 → miss evicts 0x205. Read 0x005 → hit; read 0x205 → miss.
- Write 0x005 ← 0x12345678 after 0x005 is cached → flush=1, mem_addr=0x005, mem_dout=0x12345678. Hold flush_ack low 3 cycles: busy stays 1 and req is ignored. On flush_ack: done=1, hit=0. Read 0x005 → hit, douta=0x12345678.
- Write miss to 0x0AA ← 0x1 → flush issued. Then read 0x0AA → miss (fetch=1), proving no allocate.
- Reset asserted while in FETCH with fetch_ack=1 in the same cycle → fetch=0, busy=0, done=0. Subsequent read of the same address misses.
- Spurious fetch_ack/flush_ack pulses in IDLE → no state change, no done, arrays unchanged.

Source files
------------

// File: rtl/set_assoc_write_through_cache.sv
`default_nettype none
// ============================================================================
// Module      : set_assoc_write_through_cache
// Description : 2-way set-associative, write-through, no-write-allocate cache
//               between the CPU port and the RAM controller. It uses per-set
//               LRU replacement and a req/busy handshake. Data returned by a
//               fetch is forwarded straight to douta.
// Revision    : 1.0 - initial release
// ============================================================================
module set_assoc_write_through_cache #(
    parameter int ADDRESS_SPACE = 12,
    parameter int DATA_SIZE     = 32,
    parameter int SET_BITS      = 9,
    parameter int TAG_BITS      = ADDRESS_SPACE - SET_BITS
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     req,
    input  logic                     wea,
    input  logic [ADDRESS_SPACE-1:0] addra,
    input  logic [DATA_SIZE-1:0]     dina,
    output logic [DATA_SIZE-1:0]     douta,
    output logic                     done,
    output logic                     hit,
    output logic                     busy,
    output logic                     fetch,
    output logic                     flush,
    output logic [ADDRESS_SPACE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]     mem_dout,
    input  logic [DATA_SIZE-1:0]     mem_din,
    input  logic                     fetch_ack,
    input  logic                     flush_ack
);

    localparam int c_NUM_SETS = 1 << SET_BITS;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    // Line storage: the valid and LRU bits are resettable. Tag and data
    // are plain arrays because an invalid line never hits.
    logic [c_NUM_SETS-1:0] r_valid0;
    logic [c_NUM_SETS-1:0] r_valid1;
    logic [c_NUM_SETS-1:0] r_lru;
    logic [TAG_BITS-1:0]   r_tag0  [c_NUM_SETS];
    logic [TAG_BITS-1:0]   r_tag1  [c_NUM_SETS];
    logic [DATA_SIZE-1:0]  r_data0 [c_NUM_SETS];
    logic [DATA_SIZE-1:0]  r_data1 [c_NUM_SETS];

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [SET_BITS-1:0]      r_idx;
    logic [TAG_BITS-1:0]      r_tag;
    logic [DATA_SIZE-1:0]     r_douta;
    logic                     r_done;
    logic                     r_hit;
    logic                     r_busy;
    logic                     r_fetch;
    logic                     r_flush;
    logic [ADDRESS_SPACE-1:0] r_mem_addr;
    logic [DATA_SIZE-1:0]     r_mem_dout;

    logic [SET_BITS-1:0]  w_idx;
    logic [TAG_BITS-1:0]  w_tag;
    logic                 w_hit0;
    logic                 w_hit1;
    logic                 w_lookup_hit;
    logic                 w_hit_way;
    logic [DATA_SIZE-1:0] w_hit_data;
    logic                 w_victim;
    logic                 w_idle_req;
    logic                 w_fill;

    assign w_idx        = addra[SET_BITS-1:0];
    assign w_tag        = addra[ADDRESS_SPACE-1:SET_BITS];
    assign w_hit0       = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1       = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_lookup_hit = w_hit0 || w_hit1;
    assign w_hit_way    = !w_hit0;
    assign w_hit_data   = w_hit0 ? r_data0[w_idx] : r_data1[w_idx];

    // Victim selection: an empty way is used first (way0 preferred).
    // When both ways are valid, the way named by the LRU bit is evicted.
    assign w_victim = !r_valid0[r_idx] ? 1'b0 :
                      !r_valid1[r_idx] ? 1'b1 : r_lru[r_idx];

    assign w_idle_req = (r_state == c_ST_IDLE) && req;
    assign w_fill     = (r_state == c_ST_FETCH) && fetch_ack;

    assign douta    = r_douta;
    assign done     = r_done;
    assign hit      = r_hit;
    assign busy     = r_busy;
    assign fetch    = r_fetch;
    assign flush    = r_flush;
    assign mem_addr = r_mem_addr;
    assign mem_dout = r_mem_dout;

    // State register
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: read hits stay in IDLE, writes always go to RAM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (req) begin
                    if (wea) begin
                        w_state_next = c_ST_FLUSH;
                    end else if (!w_lookup_hit) begin
                        w_state_next = c_ST_FETCH;
                    end
                end
            end
            c_ST_FETCH: if (fetch_ack) w_state_next = c_ST_IDLE;
            c_ST_FLUSH: if (flush_ack) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Handshake outputs, valid/LRU bookkeeping and the latched miss address
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_valid0   <= '0;
            r_valid1   <= '0;
            r_lru      <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_douta    <= '0;
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
            r_busy     <= 1'b0;
            r_fetch    <= 1'b0;
            r_flush    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_dout <= '0;
        end else begin
            r_done <= 1'b0;
            r_hit  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (req) begin
                        r_idx <= w_idx;
                        r_tag <= w_tag;
                        if (!wea) begin
                            if (w_lookup_hit) begin
                                r_douta      <= w_hit_data;
                                r_done       <= 1'b1;
                                r_hit        <= 1'b1;
                                r_lru[w_idx] <= !w_hit_way;
                            end else begin
                                r_fetch    <= 1'b1;
                                r_busy     <= 1'b1;
                                r_mem_addr <= addra;
                            end
                        end else begin
                            if (w_lookup_hit) begin
                                r_lru[w_idx] <= !w_hit_way;
                            end
                            r_flush    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_mem_addr <= addra;
                            r_mem_dout <= dina;
                        end
                    end
                end
                c_ST_FETCH: begin
                    if (fetch_ack) begin
                        if (w_victim) begin
                            r_valid1[r_idx] <= 1'b1;
                        end else begin
                            r_valid0[r_idx] <= 1'b1;
                        end
                        r_lru[r_idx] <= !w_victim;
                        r_douta      <= mem_din;
                        r_done       <= 1'b1;
                        r_fetch      <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                c_ST_FLUSH: begin
                    if (flush_ack) begin
                        r_flush <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_fetch <= 1'b0;
                    r_flush <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays: write-hit update in IDLE and line fill on fetch_ack
    always_ff @(posedge clka) begin
        if (!rsta) begin
            if (w_idle_req && wea && w_lookup_hit) begin
                if (w_hit_way) begin
                    r_data1[w_idx] <= dina;
                end else begin
                    r_data0[w_idx] <= dina;
                end
            end
            if (w_fill) begin
                if (w_victim) begin
                    r_tag1[r_idx]  <= r_tag;
                    r_data1[r_idx] <= mem_din;
                end else begin
                    r_tag0[r_idx]  <= r_tag;
                    r_data0[r_idx] <= mem_din;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_write_through_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_assoc_write_through_cache
// Description : Directed, table-driven bench for the 2-way write-through cache
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_assoc_write_through_cache;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic        req = 1'b0;
    logic        wea = 1'b0;
    logic [11:0] addra = '0;
    logic [31:0] dina = '0;
    logic [31:0] douta;
    logic        done;
    logic        hit;
    logic        busy;
    logic        fetch;
    logic        flush;
    logic [11:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din = '0;
    logic        fetch_ack = 1'b0;
    logic        flush_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_dout = '0;

    typedef struct {
        logic        wea;
        logic [11:0] addr;
        logic [31:0] din;
        logic        exp_hit;
        logic [31:0] exp_dout;
        int          delay;
    } vec_t;

    vec_t vecs[14];

    set_assoc_write_through_cache dut (
        .clka      (clka),
        .rsta      (rsta),
        .req       (req),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .douta     (douta),
        .done      (done),
        .hit       (hit),
        .busy      (busy),
        .fetch     (fetch),
        .flush     (flush),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .fetch_ack (fetch_ack),
        .flush_ack (flush_ack)
    );

    always #5 clka = ~clka;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One CPU transaction; misses and writes are completed by the RAM side
    // after v.delay idle cycles, during which a stray req is offered.
    task automatic run_vec(input int i, input vec_t v);
        @(negedge clka);
        req   = 1'b1;
        wea   = v.wea;
        addra = v.addr;
        dina  = v.wea ? v.din : 32'hCAFE0000;
        @(posedge clka);
        #1;
        req = 1'b0;
        if (!v.wea && v.exp_hit) begin
            check($sformatf("v%0d hit_done", i), {31'd0, done}, 32'd1);
            check($sformatf("v%0d hit_flag", i), {31'd0, hit}, 32'd1);
            check($sformatf("v%0d hit_douta", i), douta, v.exp_dout);
            model_dout = v.exp_dout;
        end else begin
            check($sformatf("v%0d req_done", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d req_busy", i), {31'd0, busy}, 32'd1);
            check($sformatf("v%0d mem_addr", i), {20'd0, mem_addr}, {20'd0, v.addr});
            if (v.wea) begin
                check($sformatf("v%0d flush", i), {31'd0, flush}, 32'd1);
                check($sformatf("v%0d mem_dout", i), mem_dout, v.din);
            end else begin
                check($sformatf("v%0d fetch", i), {31'd0, fetch}, 32'd1);
            end
            for (int k = 0; k < v.delay; k++) begin
                @(negedge clka);
                req   = 1'b1;
                wea   = 1'b0;
                addra = 12'h3FF;
                @(posedge clka);
                #1;
                req = 1'b0;
                check($sformatf("v%0d wait_busy", i), {31'd0, busy}, 32'd1);
                check($sformatf("v%0d wait_done", i), {31'd0, done}, 32'd0);
            end
            @(negedge clka);
            if (v.wea) begin
                flush_ack = 1'b1;
            end else begin
                fetch_ack = 1'b1;
                mem_din   = v.din;
            end
            @(posedge clka);
            #1;
            fetch_ack = 1'b0;
            flush_ack = 1'b0;
            if (!v.wea) model_dout = v.din;
            check($sformatf("v%0d cmp_done", i), {31'd0, done}, 32'd1);
            check($sformatf("v%0d cmp_hit", i), {31'd0, hit}, 32'd0);
            check($sformatf("v%0d cmp_busy", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d cmp_req", i), {30'd0, fetch, flush}, 32'd0);
            check($sformatf("v%0d cmp_douta", i), douta, model_dout);
        end
    endtask

    initial begin
        // Set 5 holds tags of 0x005, 0x205 and 0x405 in turn.
        vecs[0]  = '{1'b0, 12'h005, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 0};
        vecs[1]  = '{1'b0, 12'h005, 32'h0,        1'b1, 32'hDEADBEEF, 0};
        vecs[2]  = '{1'b0, 12'h205, 32'hA5A50205, 1'b0, 32'hA5A50205, 0};
        vecs[3]  = '{1'b0, 12'h005, 32'h0,        1'b1, 32'hDEADBEEF, 0};
        vecs[4]  = '{1'b0, 12'h405, 32'h00000405, 1'b0, 32'h00000405, 0};
        vecs[5]  = '{1'b0, 12'h005, 32'h0,        1'b1, 32'hDEADBEEF, 0};
        vecs[6]  = '{1'b0, 12'h205, 32'h22220205, 1'b0, 32'h22220205, 0};
        vecs[7]  = '{1'b0, 12'h205, 32'h0,        1'b1, 32'h22220205, 0};
        vecs[8]  = '{1'b0, 12'h005, 32'h0,        1'b1, 32'hDEADBEEF, 0};
        vecs[9]  = '{1'b1, 12'h005, 32'h12345678, 1'b0, 32'h0,        3};
        vecs[10] = '{1'b0, 12'h005, 32'h0,        1'b1, 32'h12345678, 0};
        vecs[11] = '{1'b1, 12'h0AA, 32'h00000001, 1'b0, 32'h0,        0};
        vecs[12] = '{1'b0, 12'h0AA, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 2};
        vecs[13] = '{1'b0, 12'h0AA, 32'h0,        1'b1, 32'h0BADF00D, 0};

        // Reset state
        repeat (2) @(posedge clka);
        #1;
        check("rst_douta", douta, 32'h0);
        check("rst_ctrl", {26'd0, done, hit, busy, fetch, flush, 1'b0}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_mem_dout", mem_dout, 32'h0);
        @(negedge clka);
        rsta = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back read hits, req held high across two edges
        @(negedge clka);
        req = 1'b1; wea = 1'b0; addra = 12'h005;
        @(posedge clka);
        #1;
        check("b2b0_done", {31'd0, done & hit}, 32'd1);
        check("b2b0_douta", douta, 32'h12345678);
        @(negedge clka);
        addra = 12'h205;
        @(posedge clka);
        #1;
        req = 1'b0;
        check("b2b1_done", {31'd0, done & hit}, 32'd1);
        check("b2b1_douta", douta, 32'h22220205);
        model_dout = 32'h22220205;

        // Spurious acks while idle
        @(negedge clka);
        fetch_ack = 1'b1; flush_ack = 1'b1; mem_din = 32'hFFFFFFFF;
        @(posedge clka);
        #1;
        fetch_ack = 1'b0; flush_ack = 1'b0;
        check("spur_ctrl", {28'd0, done, busy, fetch, flush}, 32'd0);
        check("spur_douta", douta, model_dout);
        run_vec(100, '{1'b0, 12'h005, 32'h0, 1'b1, 32'h12345678, 0});
        run_vec(101, '{1'b0, 12'h205, 32'h0, 1'b1, 32'h22220205, 0});

        // Reset during FETCH with a simultaneous fetch_ack
        @(negedge clka);
        req = 1'b1; wea = 1'b0; addra = 12'h123;
        @(posedge clka);
        #1;
        req = 1'b0;
        check("rf_fetch", {31'd0, fetch}, 32'd1);
        @(negedge clka);
        fetch_ack = 1'b1; mem_din = 32'h00000055; rsta = 1'b1;
        @(posedge clka);
        #1;
        check("rf_ctrl", {29'd0, done, busy, fetch}, 32'd0);
        check("rf_douta", douta, 32'h0);
        @(negedge clka);
        rsta = 1'b0; fetch_ack = 1'b0;
        model_dout = 32'h0;
        run_vec(200, '{1'b0, 12'h123, 32'h77777777, 1'b0, 32'h77777777, 1});
        run_vec(201, '{1'b0, 12'h005, 32'hABCD0005, 1'b0, 32'hABCD0005, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
